// File: rtl/popcnt_window_pkg.sv
// Shared types and size helpers for the windowed population counter.
package popcnt_window_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Number of 6-bit groups needed to tile a WIDTH-bit word.
    function automatic int calc_ngroups(input int width);
        return (width + 5) / 6;
    endfunction

    // Bits needed to hold a count in 0..width.
    function automatic int calc_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/popcnt_window_popcnt6.sv
// 6-bit population count primitive; ABSTRACT_MODEL selects a plain sum
// instead of the explicit full-adder tree.
module popcnt6 #(
    parameter int ABSTRACT_MODEL = 0
) (
    input  logic [5:0] i_x,
    output logic [2:0] o_cnt
);

    generate
        if (ABSTRACT_MODEL != 0) begin : g_abstract
            assign o_cnt = 3'(i_x[0]) + 3'(i_x[1]) + 3'(i_x[2])
                         + 3'(i_x[3]) + 3'(i_x[4]) + 3'(i_x[5]);
        end else begin : g_tree
            logic s_lo, c_lo, s_hi, c_hi;
            // Two full adders compress each triple to a 2-bit count.
            assign s_lo = i_x[0] ^ i_x[1] ^ i_x[2];
            assign c_lo = (i_x[0] & i_x[1]) | (i_x[2] & (i_x[0] ^ i_x[1]));
            assign s_hi = i_x[3] ^ i_x[4] ^ i_x[5];
            assign c_hi = (i_x[3] & i_x[4]) | (i_x[5] & (i_x[3] ^ i_x[4]));
            assign o_cnt = {1'b0, c_lo, s_lo} + {1'b0, c_hi, s_hi};
        end
    endgenerate

endmodule

// File: rtl/popcnt_window.sv
// Streaming windowed population counter: per-sample popcount, accumulated
// over WINDOW_LEN valid samples. Define POPCNT_WINDOW_SATURATE_EN to clamp.
module popcnt_window
    import popcnt_window_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int WINDOW_LEN     = 16,
    parameter int ACC_W          = 16,
    parameter int ABSTRACT_MODEL = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_clear,
    output logic             o_valid,
    output logic [ACC_W-1:0] o_total,
    output logic             o_overflow,
    output logic             o_busy
);

    localparam int NGROUPS = calc_ngroups(WIDTH);
    localparam int PAD_W   = NGROUPS * 6;
    localparam int CNT_W   = calc_cnt_w(WIDTH);
    localparam int NS_W    = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;

    logic [PAD_W-1:0]          x_pad;
    logic [NGROUPS-1:0][2:0]   grp_cnt;
    logic [CNT_W-1:0]          cnt_sum;

    logic [CNT_W-1:0]          s1_cnt;
    logic                      s1_vld;

    logic [ACC_W-1:0]          acc;
    logic [NS_W-1:0]           nsamp;
    logic                      sticky;
    logic                      vld_r;
    state_t                    state;

    logic [ACC_W:0]            acc_sum;
    logic                      carry;
    logic [ACC_W-1:0]          acc_next;
    logic                      last_smp;

    always_comb begin
        x_pad = '0;
        x_pad[WIDTH-1:0] = i_x;
    end

    for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
        popcnt6 #(.ABSTRACT_MODEL(ABSTRACT_MODEL)) u_pc6 (
            .i_x   (x_pad[g*6 +: 6]),
            .o_cnt (grp_cnt[g])
        );
    end

    always_comb begin
        cnt_sum = '0;
        for (int g = 0; g < NGROUPS; g++)
            cnt_sum += CNT_W'(grp_cnt[g]);
    end

    // A clear drops the sample arriving with it as well as the one in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld <= 1'b0;
            s1_cnt <= '0;
        end else if (i_cg) begin
            s1_vld <= i_valid & ~i_clear;
            s1_cnt <= cnt_sum;
        end
    end

    always_comb begin
        acc_sum = {1'b0, acc} + (ACC_W+1)'(s1_cnt);
        carry   = acc_sum[ACC_W];
`ifdef POPCNT_WINDOW_SATURATE_EN
        acc_next = carry ? '1 : acc_sum[ACC_W-1:0];
`else
        acc_next = acc_sum[ACC_W-1:0];
`endif
        last_smp = (nsamp == NS_W'(WINDOW_LEN - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc        <= '0;
            nsamp      <= '0;
            sticky     <= 1'b0;
            vld_r      <= 1'b0;
            o_total    <= '0;
            o_overflow <= 1'b0;
            state      <= IDLE;
        end else if (i_cg) begin
            vld_r <= 1'b0;
            if (i_clear) begin
                acc    <= '0;
                nsamp  <= '0;
                sticky <= 1'b0;
                state  <= IDLE;
            end else if (s1_vld) begin
                if (last_smp) begin
                    o_total    <= acc_next;
                    o_overflow <= sticky | carry;
                    vld_r      <= 1'b1;
                    acc        <= '0;
                    nsamp      <= '0;
                    sticky     <= 1'b0;
                    state      <= IDLE;
                end else begin
                    acc    <= acc_next;
                    nsamp  <= nsamp + NS_W'(1);
                    sticky <= sticky | carry;
                    state  <= ACCUM;
                end
            end
        end
    end

    // The pulse is held while gated off and shows on the next enabled cycle.
    assign o_valid = vld_r & i_cg;
    assign o_busy  = (state == ACCUM);

endmodule

// File: tb/tb_popcnt_window.sv
// Bench for popcnt_window: three configurations driven in lockstep against a
// window-level reference model.
module tb_popcnt_window;

`ifdef POPCNT_WINDOW_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int WLEN = 4;

    logic        clk = 1'b0;
    logic        rst, cg, valid, clear;
    logic [31:0] x;

    logic        vld[3], ovf[3], busy[3];
    logic [7:0]  tot[3];
    logic [7:0]  tot_a, tot_c;
    logic [5:0]  tot_b;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int  n[3], s[3], pend_c[3], last_t[3];
    bit  last_o[3], pulse[3], e_vld[3];
    bit  pend_v;
    int  acc_max[3] = '{255, 63, 255};

    always #5 clk = ~clk;

    assign tot[0] = tot_a;
    assign tot[1] = {2'b00, tot_b};
    assign tot[2] = tot_c;

    popcnt_window #(.WIDTH(32), .WINDOW_LEN(WLEN), .ACC_W(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_valid(valid), .i_x(x),
        .i_clear(clear), .o_valid(vld[0]), .o_total(tot_a),
        .o_overflow(ovf[0]), .o_busy(busy[0]));

    popcnt_window #(.WIDTH(32), .WINDOW_LEN(WLEN), .ACC_W(6)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_valid(valid), .i_x(x),
        .i_clear(clear), .o_valid(vld[1]), .o_total(tot_b),
        .o_overflow(ovf[1]), .o_busy(busy[1]));

    popcnt_window #(.WIDTH(7), .WINDOW_LEN(WLEN), .ACC_W(8), .ABSTRACT_MODEL(1)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_valid(valid), .i_x(x[6:0]),
        .i_clear(clear), .o_valid(vld[2]), .o_total(tot_c),
        .o_overflow(ovf[2]), .o_busy(busy[2]));

    // One clock: apply inputs, advance the window model at the edge, and
    // leave the bench at the following negedge ready to compare.
    task automatic step(input bit r, input bit v, input bit c, input bit g,
                        input logic [31:0] xx);
        logic [6:0] x7;
        rst = r; valid = v; clear = c; cg = g; x = xx;
        x7 = xx[6:0];
        @(posedge clk);
        if (r) begin
            pend_v = 1'b0;
            for (int d = 0; d < 3; d++) begin
                n[d] = 0; s[d] = 0; pulse[d] = 1'b0; last_t[d] = 0; last_o[d] = 1'b0;
            end
        end else if (g) begin
            for (int d = 0; d < 3; d++) begin
                pulse[d] = 1'b0;
                if (c) begin
                    n[d] = 0; s[d] = 0;
                end else if (pend_v) begin
                    s[d] += pend_c[d];
                    n[d]++;
                    if (n[d] == WLEN) begin
                        pulse[d]  = 1'b1;
                        last_o[d] = (s[d] > acc_max[d]);
                        if (SAT) last_t[d] = (s[d] > acc_max[d]) ? acc_max[d] : s[d];
                        else     last_t[d] = s[d] % (acc_max[d] + 1);
                        n[d] = 0; s[d] = 0;
                    end
                end
            end
            pend_v    = v && !c;
            pend_c[0] = $countones(xx);
            pend_c[1] = $countones(xx);
            pend_c[2] = $countones(x7);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) e_vld[d] = pulse[d] && g;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 1, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (vld[d] !== 1'b0 || tot[d] !== 8'd0 || ovf[d] !== 1'b0 || busy[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got vld=%b tot=%0d ovf=%b busy=%b, want all 0",
                         d, vld[d], tot[d], ovf[d], busy[d]);
            end
        end
    endtask

    task automatic test_full_ones();
        step(1, 0, 0, 1, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 32'hFFFF_FFFF);
        n_tests++;
        if (vld[0] !== 1'b0) begin
            n_fail++; $display("FAIL full_ones_early: got vld=%b want 0", vld[0]);
        end
        step(0, 0, 0, 1, 32'h0);
        n_tests++;
        if (vld[0] !== 1'b1 || tot[0] !== 8'd128 || ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ones_a: got vld=%b tot=%0d ovf=%b, want 1 128 0", vld[0], tot[0], ovf[0]);
        end
        n_tests++;
        if (vld[1] !== 1'b1 || tot[1] !== (SAT ? 8'd63 : 8'd0) || ovf[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_b: got vld=%b tot=%0d ovf=%b, want 1 %0d 1",
                     vld[1], tot[1], ovf[1], SAT ? 63 : 0);
        end
        n_tests++;
        if (vld[2] !== 1'b1 || tot[2] !== 8'd28 || ovf[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL padding_c: got vld=%b tot=%0d ovf=%b, want 1 28 0", vld[2], tot[2], ovf[2]);
        end
        step(0, 0, 0, 1, 32'h0);
        n_tests++;
        if (vld[0] !== 1'b0 || tot[0] !== 8'd128) begin
            n_fail++; $display("FAIL full_ones_hold: got vld=%b tot=%0d, want 0 128", vld[0], tot[0]);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] xs[10] = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h3, 32'h7, 32'hF, 32'h0, 32'h0, 32'h0};
        bit          vs[10] = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        bit          bexp[10] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        int pulses = 0;
        int bad_busy = 0;
        step(1, 0, 0, 1, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(0, vs[i], 0, 1, xs[i]);
            if (vld[0] === 1'b1) pulses++;
            if (busy[0] !== bexp[i]) bad_busy++;
        end
        n_tests++;
        if (pulses != 1 || tot[0] !== 8'd10) begin
            n_fail++; $display("FAIL gaps_total: got pulses=%0d tot=%0d, want 1 10", pulses, tot[0]);
        end
        n_tests++;
        if (bad_busy != 0) begin
            n_fail++; $display("FAIL gaps_busy: got %0d wrong cycles, want 0", bad_busy);
        end
    endtask

    task automatic test_back_to_back();
        int pc[$];
        int bad_tot = 0;
        step(1, 0, 0, 1, 32'h0);
        for (int i = 0; i < 14; i++) begin
            step(0, i < 8, 0, 1, 32'hFF);
            if (vld[0] === 1'b1) begin
                pc.push_back(i);
                if (tot[0] !== 8'd32) bad_tot++;
            end
        end
        n_tests++;
        if (pc.size() != 2 || bad_tot != 0) begin
            n_fail++; $display("FAIL b2b_count: got pulses=%0d bad_tot=%0d, want 2 0", pc.size(), bad_tot);
        end else begin
            n_tests++;
            if (pc[1] - pc[0] != 4) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d want 4", pc[1] - pc[0]);
            end
        end
    endtask

    task automatic test_clear();
        int pulses = 0;
        step(1, 0, 0, 1, 32'h0);
        step(0, 1, 0, 1, 32'hFFFF_FFFF);
        step(0, 1, 0, 1, 32'hFFFF_FFFF);
        step(0, 0, 1, 1, 32'h0);
        n_tests++;
        if (busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL clear_busy: got %b want 0", busy[0]);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, i < 4, 0, 1, 32'h1);
            if (vld[0] === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 1 || tot[0] !== 8'd4) begin
            n_fail++; $display("FAIL clear_total: got pulses=%0d tot=%0d, want 1 4", pulses, tot[0]);
        end
    endtask

    task automatic test_padding_reset();
        int pulses = 0;
        step(1, 0, 0, 1, 32'h0);
        for (int i = 0; i < 5; i++) step(0, i < 4, 0, 1, 32'h7F);
        n_tests++;
        if (tot[2] !== 8'd28) begin
            n_fail++; $display("FAIL pad_total: got %0d want 28", tot[2]);
        end
        step(0, 1, 0, 1, 32'h7F);
        step(0, 1, 0, 1, 32'h7F);
        step(0, 0, 0, 1, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 32'h0);
            if (vld[2] === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0 || tot[2] !== 8'd0 || ovf[2] !== 1'b0 || busy[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL pad_reset: got pulses=%0d tot=%0d ovf=%b busy=%b, want 0 0 0 0",
                     pulses, tot[2], ovf[2], busy[2]);
        end
    endtask

    task automatic test_clock_gate();
        int bad = 0;
        step(1, 0, 0, 1, 32'h0);
        for (int i = 0; i < 200; i++) begin
            step(0, $urandom_range(0, 2) != 0, 0, $urandom_range(0, 2) != 0,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom());
            for (int d = 0; d < 3; d++) begin
                n_tests++;
                if (vld[d] !== e_vld[d] || tot[d] !== 8'(last_t[d]) ||
                    ovf[d] !== last_o[d] || busy[d] !== (n[d] > 0)) begin
                    n_fail++; bad++;
                    if (bad < 10)
                        $display("FAIL cg dut%0d cyc%0d: got vld=%b tot=%0d ovf=%b busy=%b, want %b %0d %b %b",
                                 d, i, vld[d], tot[d], ovf[d], busy[d],
                                 e_vld[d], last_t[d], last_o[d], n[d] > 0);
                end
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        step(1, 0, 0, 1, 32'h0);
        for (int i = 0; i < 300; i++) begin
            step(0, $urandom_range(0, 4) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) != 0,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom());
            for (int d = 0; d < 3; d++) begin
                n_tests++;
                if (vld[d] !== e_vld[d] || tot[d] !== 8'(last_t[d]) ||
                    ovf[d] !== last_o[d] || busy[d] !== (n[d] > 0)) begin
                    n_fail++; bad++;
                    if (bad < 10)
                        $display("FAIL rand dut%0d cyc%0d: got vld=%b tot=%0d ovf=%b busy=%b, want %b %0d %b %b",
                                 d, i, vld[d], tot[d], ovf[d], busy[d],
                                 e_vld[d], last_t[d], last_o[d], n[d] > 0);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; cg = 1'b1; valid = 1'b0; clear = 1'b0; x = '0;
        @(negedge clk);
        test_reset();
        test_full_ones();
        test_gaps();
        test_back_to_back();
        test_clear();
        test_padding_reset();
        test_clock_gate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/popcnt_window.md
# popcnt_window

Streaming windowed population counter: each valid cycle it counts the set bits of a WIDTH-bit sample and accumulates the counts over WINDOW_LEN valid samples, then emits the window total for one cycle. It sits directly downstream of the 6-bit population-count primitive, tiling it across the input word and summing the group results, and feeds statistics/correlation logic that needs per-window bit densities.

## Interface
- WIDTH, 32: input sample width in bits, ≥1.
- WINDOW_LEN, 16: valid samples per window, ≥1.
- ACC_W, 16: width of accumulator and o_total.
- ABSTRACT_MODEL, 0: passed to every popcnt6 instance.

- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_cg  input  1  clock-gate enable; when 0 all state holds, o_valid forced 0.
- i_valid  input  1  i_x carries a sample this cycle.
- i_x  input  WIDTH  sample.
- i_clear  input  1  abort current window, discard everything in flight.
- o_valid  output  1  one-cycle pulse, o_total/o_overflow valid.
- o_total  output  ACC_W  window total, held until next o_valid.
- o_overflow  output  1  window total exceeded 2^ACC_W−1; updated with o_valid.
- o_busy  output  1  window partially accumulated (state ACCUM).

## Operation
- Stage 0 (combinational): i_x zero-padded to NGROUPS×6, NGROUPS = ceil(WIDTH/6); one popcnt6 per group; group counts summed to CNT_W = $clog2(WIDTH+1) bits.
- Stage 1 (register): s1_cnt, s1_vld ← stage-0 sum, i_valid. Always loaded when i_cg=1.
- Stage 2 (accumulate) when s1_vld: sum = acc + s1_cnt (ACC_W+1 bits); sample counter nsamp increments.
- Final sample (nsamp == WINDOW_LEN−1 with s1_vld): o_total ← result, o_overflow ← sticky flag | carry, o_valid ← 1; acc, nsamp, sticky cleared same edge. No bubble: next sample accumulates into fresh window.
- States: IDLE (nsamp=0), ACCUM (0<nsamp<WINDOW_LEN). IDLE→ACCUM on non-final accepted sample; ACCUM→IDLE on final sample or i_clear. WINDOW_LEN=1: every sample is final, never enters ACCUM.
- i_valid gaps: no effect on window content; window spans exactly WINDOW_LEN valid samples.
- i_clear (priority over accumulation): s1_vld, acc, nsamp, sticky cleared; no o_valid; o_total/o_overflow retain previous values; i_valid sample in same cycle discarded.
- Without saturation: acc wraps modulo 2^ACC_W; any carry sets sticky overflow.

## Timing
- Reset values: o_valid=0, o_total=0, o_overflow=0, o_busy=0, acc=0, nsamp=0, s1_vld=0.
- Latency: final sample presented in cycle t → o_valid high in cycle t+2.
- Throughput: one sample per cycle, indefinitely.
- Reset mid-window: partial window discarded, no o_valid.
- i_cg=0: samples ignored, pipeline frozen, resumes unchanged on i_cg=1.

## Configuration
- POPCNT_WINDOW_SATURATE_EN defined: acc clamps at 2^ACC_W−1; o_overflow still set when clamping occurred.
- Undefined: acc wraps modulo 2^ACC_W, o_overflow reports wrap.

## Structure
- Shared package: function for NGROUPS/CNT_W derivation, state enum (IDLE, ACCUM).
- Sub-module: popcnt6, instantiated NGROUPS times in a generate loop; no other hierarchy.

## Test plan
- WIDTH=32, WINDOW_LEN=4, ACC_W=8: four back-to-back 32'hFFFFFFFF → o_valid in cycle t+2 after 4th, o_total=128, o_overflow=0.
- Same config, samples 32'h1, gap 3 cycles, 32'h3, 32'h7, 32'hF → o_total=10 exactly once; o_busy high from cycle after first accumulate until final.
- ACC_W=6, four 32'hFFFFFFFF → without macro o_total=0, o_overflow=1; with POPCNT_WINDOW_SATURATE_EN o_total=63, o_overflow=1.
- Two windows back-to-back (8 samples of 32'hFF) → two o_valid pulses 4 cycles apart, each o_total=32.
- Two samples, i_clear, then four 32'h1 → single o_valid, o_total=4.
- WIDTH=7 (padding): four 7'h7F → o_total=28; i_rst asserted after second sample → no o_valid, all outputs 0.
